// File: rtl/artemis_rst_pkg.sv
// artemis_rst_pkg -- shared types and defaults for the ARTEMIS reset sequencer.
//   state_t      : sequencer states
//   rst_outs_t   : registered output bundle, produced by decode()
//   DEF_*        : default values for the five sequencer parameters
//   cnt_width()  : width of the shared down-counter for a given set of loads
package artemis_rst_pkg;

  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_DDR_RST_CYCLES      = 64;
  localparam int DEF_MAX_RETRIES         = 3;

  localparam int RETRY_W = 2;

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_DDR_RST,
    S_WAIT_CALIB,
    S_RUN,
    S_FAULT
  } state_t;

  typedef struct packed {
    logic pll_rst;
    logic ddr3_rst;
    logic sys_rst;
    logic ready;
    logic fault;
  } rst_outs_t;

  // Output levels are a pure function of the state.
  function automatic rst_outs_t decode(state_t s);
    rst_outs_t o;
    o.pll_rst  = (s == S_PLL_RST);
    o.ddr3_rst = !((s == S_WAIT_CALIB) || (s == S_RUN));
    o.sys_rst  = (s != S_RUN);
    o.ready    = (s == S_RUN);
    o.fault    = (s == S_FAULT);
    return o;
  endfunction

  // Counter must hold the largest reload value.
  function automatic int cnt_width(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/artemis_rst_seq_if.sv
// artemis_rst_seq_if -- status/control bundle between the reset sequencer and
// the PLL / DDR3 / fabric it supervises.
//   pll_locked, calib_done : raw status inputs (asynchronous to clk)
//   pll_rst, ddr3_rst, sys_rst, ready, fault, retry_count : sequencer outputs
//   modport master : the sequencer
//   modport slave  : the supervised environment
interface artemis_rst_seq_if;
  import artemis_rst_pkg::*;

  logic               pll_locked;
  logic               calib_done;
  logic               pll_rst;
  logic               ddr3_rst;
  logic               sys_rst;
  logic               ready;
  logic               fault;
  logic [RETRY_W-1:0] retry_count;

  modport master (
    input  pll_locked, calib_done,
    output pll_rst, ddr3_rst, sys_rst, ready, fault, retry_count
  );

  modport slave (
    output pll_locked, calib_done,
    input  pll_rst, ddr3_rst, sys_rst, ready, fault, retry_count
  );
endinterface

// File: rtl/artemis_sync2.sv
// artemis_sync2 -- 1-bit two-flop synchronizer with synchronous active-high
// clear.
//   clk : destination clock
//   rst : synchronous clear, both flops to 0
//   d   : asynchronous input
//   q   : synchronized output, two clk cycles of latency
module artemis_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/artemis_rst_seq.sv
// artemis_rst_seq -- power-up reset sequencer for PLL, DDR3 controller and
// system fabric.
//   clk : reference clock, independent of the PLL
//   rst : synchronous active-high reset
//   io  : artemis_rst_seq_if.master (pll_locked, calib_done in;
//         pll_rst, ddr3_rst, sys_rst, ready, fault, retry_count out)
// Sequence: PLL reset pulse -> wait for lock -> lock must stay up for a
// stability window -> DDR3 reset hold -> (optional calibration wait) -> run.
// Lock/calibration timeouts retry from the PLL reset up to MAX_RETRIES times,
// after which the block parks in S_FAULT until rst.
// Build option: define ARTEMIS_RST_CALIB_WAIT_EN to wait for calib_done after
// the DDR3 reset hold; otherwise calib_done is ignored.
module artemis_rst_seq
  import artemis_rst_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int DDR_RST_CYCLES      = DEF_DDR_RST_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic              clk,
  input  logic              rst,
  artemis_rst_seq_if.master io
);

  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                   LOCK_TIMEOUT_CYCLES, DDR_RST_CYCLES);

  localparam logic [CNT_W-1:0]   LD_PLL    = CNT_W'(PLL_RST_CYCLES);
  localparam logic [CNT_W-1:0]   LD_STABLE = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0]   LD_TO     = CNT_W'(LOCK_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]   LD_DDR    = CNT_W'(DDR_RST_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  if (MAX_RETRIES < 0 || MAX_RETRIES > 3) begin : g_bad_retries
    $error("artemis_rst_seq: MAX_RETRIES must be in 0..3");
  end
  if (PLL_RST_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 ||
      LOCK_TIMEOUT_CYCLES < 1 || DDR_RST_CYCLES < 1) begin : g_bad_cycles
    $error("artemis_rst_seq: cycle parameters must be at least 1");
  end

  logic lock_s;
  logic calib_s;

  artemis_sync2 u_sync_lock (.clk(clk), .rst(rst), .d(io.pll_locked), .q(lock_s));

`ifdef ARTEMIS_RST_CALIB_WAIT_EN
  artemis_sync2 u_sync_calib (.clk(clk), .rst(rst), .d(io.calib_done), .q(calib_s));
  localparam state_t DDR_NEXT = S_WAIT_CALIB;
`else
  logic calib_unused;
  assign calib_unused = io.calib_done;
  assign calib_s      = 1'b0;
  localparam state_t DDR_NEXT = S_RUN;
`endif

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry;
  rst_outs_t          outs;

  // Timeout target: retry from the PLL pulse, or give up once retries are spent.
  state_t             to_next;
  logic [RETRY_W-1:0] retry_inc;
  assign to_next   = (retry == RETRY_MAX) ? S_FAULT : S_PLL_RST;
  assign retry_inc = (retry == RETRY_MAX) ? retry : retry + RETRY_W'(1);

  // Counter reload for each state; S_RUN/S_FAULT do not count.
  function automatic logic [CNT_W-1:0] load(state_t s);
    case (s)
      S_PLL_RST:                 load = LD_PLL;
      S_WAIT_LOCK, S_WAIT_CALIB: load = LD_TO;
      S_STABLE:                  load = LD_STABLE;
      S_DDR_RST:                 load = LD_DDR;
      default:                   load = CNT_ONE;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_PLL_RST;
      cnt   <= LD_PLL;
      retry <= '0;
      outs  <= decode(S_PLL_RST);
    end else begin
      case (state)
        S_PLL_RST: begin
          if (cnt == CNT_ONE) begin
            state <= S_WAIT_LOCK; cnt <= LD_TO; outs <= decode(S_WAIT_LOCK);
          end else cnt <= cnt - CNT_ONE;
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state <= S_STABLE; cnt <= LD_STABLE; outs <= decode(S_STABLE);
          end else if (cnt == CNT_ONE) begin
            state <= to_next; cnt <= load(to_next); outs <= decode(to_next);
            retry <= retry_inc;
          end else cnt <= cnt - CNT_ONE;
        end
        S_STABLE: begin
          // A dropout restarts the lock wait with a fresh timeout, no retry taken.
          if (!lock_s) begin
            state <= S_WAIT_LOCK; cnt <= LD_TO; outs <= decode(S_WAIT_LOCK);
          end else if (cnt == CNT_ONE) begin
            state <= S_DDR_RST; cnt <= LD_DDR; outs <= decode(S_DDR_RST);
          end else cnt <= cnt - CNT_ONE;
        end
        S_DDR_RST: begin
          if (cnt == CNT_ONE) begin
            state <= DDR_NEXT; cnt <= load(DDR_NEXT); outs <= decode(DDR_NEXT);
          end else cnt <= cnt - CNT_ONE;
        end
        S_WAIT_CALIB: begin
          // Lock loss outranks both calibration and timeout.
          if (!lock_s) begin
            state <= S_PLL_RST; cnt <= LD_PLL; outs <= decode(S_PLL_RST);
            retry <= '0;
          end else if (calib_s) begin
            state <= S_RUN; cnt <= CNT_ONE; outs <= decode(S_RUN);
          end else if (cnt == CNT_ONE) begin
            state <= to_next; cnt <= load(to_next); outs <= decode(to_next);
            retry <= retry_inc;
          end else cnt <= cnt - CNT_ONE;
        end
        S_RUN: begin
          if (!lock_s) begin
            state <= S_PLL_RST; cnt <= LD_PLL; outs <= decode(S_PLL_RST);
            retry <= '0;
          end
        end
        S_FAULT: ;
        default: begin
          state <= S_PLL_RST; cnt <= LD_PLL; outs <= decode(S_PLL_RST);
          retry <= '0;
        end
      endcase
    end
  end

  assign io.pll_rst     = outs.pll_rst;
  assign io.ddr3_rst    = outs.ddr3_rst;
  assign io.sys_rst     = outs.sys_rst;
  assign io.ready       = outs.ready;
  assign io.fault       = outs.fault;
  assign io.retry_count = retry;

endmodule
